// File: rtl/vx_csa_resolve_pkg.sv
// rtl/vx_csa_resolve_pkg.sv - sizing helpers for the carry-save resolver
// Purpose: elaboration-time helpers that derive the segment count and the
//          segment counter width from W and CHUNK.
// Ports:   none (package)
package vx_csa_resolve_pkg;

   // Number of CHUNK-wide segments needed to cover W bits (ceiling division).
   // An illegal CHUNK yields 1 so elaboration reaches the range check in the top.
   function automatic int csa_nseg(input int w, input int chunk);
      if (chunk < 1) begin
         return 1;
      end
      return (w + chunk - 1) / chunk;
   endfunction

   // Segment counter width, never narrower than one bit.
   function automatic int csa_cnt_w(input int nseg);
      return (nseg > 1) ? $clog2(nseg) : 1;
   endfunction

endpackage

// File: rtl/vx_csa_resolve.sv
// rtl/vx_csa_resolve.sv - multi-cycle resolver of a carry-save sum/carry pair
// Purpose: adds sum_in and carry_in CHUNK bits per cycle, rippling the carry
//          between segments in a register, and hands the W-bit result plus the
//          carry out of bit W-1 to a valid/ready consumer.
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous, active-high
//   valid_in    operand pair present
//   ready_in    block can accept an operand pair
//   sum_in      sum vector of the carry-save pair (W bits)
//   carry_in    carry vector, already weight-aligned (W bits)
//   valid_out   result present (high exactly while DONE)
//   ready_out   downstream accepts the result
//   result_out  (sum_in + carry_in) mod 2^W
//   cout_out    bit W of the full-precision sum
module vx_csa_resolve
   import vx_csa_resolve_pkg::*;
#(
   parameter int W     = 16,
   parameter int CHUNK = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         valid_in,
   output logic         ready_in,
   input  logic [W-1:0] sum_in,
   input  logic [W-1:0] carry_in,
   output logic         valid_out,
   input  logic         ready_out,
   output logic [W-1:0] result_out,
   output logic         cout_out
);

   localparam int NSEG   = csa_nseg(W, CHUNK);
   localparam int CNT_W  = csa_cnt_w(NSEG);
   // Width of the final segment; 1..CHUNK when CHUNK is legal.
   localparam int LAST_W = W - (NSEG - 1) * CHUNK;
   localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(NSEG - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   if (CHUNK < 1 || CHUNK > W) begin : g_bad_chunk
      $error("vx_csa_resolve: CHUNK must lie in 1..W");
   end

   logic [1:0]       state;
   logic [CNT_W-1:0] seg_cnt;
   logic             carry_q;
   logic [W-1:0]     sum_q;
   logic [W-1:0]     op_carry_q;
   logic [W-1:0]     result_q;
   logic             cout_q;

   logic [CHUNK-1:0] seg_a;
   logic [CHUNK-1:0] seg_b;
   logic [CHUNK:0]   seg_sum;
   logic             last_seg;
   logic             seg_cout;
   logic             accept;

   assign ready_in   = (state == S_IDLE) || ((state == S_DONE) && ready_out);
   assign valid_out  = (state == S_DONE);
   assign result_out = result_q;
   assign cout_out   = cout_q;
   assign accept     = valid_in && ready_in;

   // Gather segment seg_cnt of both operands. Bits past W in a narrow final
   // segment stay zero, so its carry-out lands at bit LAST_W of seg_sum.
   always_comb begin
      seg_a = '0;
      seg_b = '0;
      for (int i = 0; i < W; i++) begin
         if (int'(seg_cnt) == i / CHUNK) begin
            seg_a[i % CHUNK] = sum_q[i];
            seg_b[i % CHUNK] = op_carry_q[i];
         end
      end
   end

   assign seg_sum  = {1'b0, seg_a} + {1'b0, seg_b} + (CHUNK+1)'(carry_q);
   assign last_seg = (seg_cnt == LAST_SEG);
   assign seg_cout = last_seg ? seg_sum[LAST_W] : seg_sum[CHUNK];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         seg_cnt    <= '0;
         carry_q    <= 1'b0;
         sum_q      <= '0;
         op_carry_q <= '0;
         result_q   <= '0;
         cout_q     <= 1'b0;
      end else if (accept) begin
         // Covers both a fresh start from IDLE and a back-to-back start
         // on the DONE cycle whose result is being taken.
         sum_q      <= sum_in;
         op_carry_q <= carry_in;
         seg_cnt    <= '0;
         carry_q    <= 1'b0;
         state      <= S_BUSY;
      end else if (state == S_BUSY) begin
         for (int i = 0; i < W; i++) begin
            if (int'(seg_cnt) == i / CHUNK) begin
               result_q[i] <= seg_sum[i % CHUNK];
            end
         end
         carry_q <= seg_cout;
         if (last_seg) begin
            cout_q  <= seg_cout;
            seg_cnt <= '0;
            state   <= S_DONE;
         end else begin
            seg_cnt <= seg_cnt + 1'b1;
         end
      end else if ((state == S_DONE) && ready_out) begin
         state <= S_IDLE;
      end else if (state != S_IDLE && state != S_DONE) begin
         state <= S_IDLE;
      end
   end

endmodule

// File: doc/vx_csa_resolve.md
VX_CSA_RESOLVE -- requirements
Module: VX_csa_resolve

Interface
REQ-001 SHALL have parameter W, default 16: bit-width of the redundant sum/carry operands and of the resolved result.
REQ-002 SHALL have parameter CHUNK, default 4: bits resolved per cycle; legal range 1..W.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port valid_in  input  1  operand pair present.
REQ-006 SHALL have port ready_in  output  1  block can accept an operand pair.
REQ-007 SHALL have port sum_in  input  W  sum vector of the carry-save pair.
REQ-008 SHALL have port carry_in  input  W  carry vector, already weight-aligned, with no shift applied inside the block.
REQ-009 SHALL have port valid_out  output  1  result present.
REQ-010 SHALL have port ready_out  input  1  downstream accepts the result.
REQ-011 SHALL have port result_out  output  W  (sum_in + carry_in) mod 2^W.
REQ-012 SHALL have port cout_out  output  1  bit W of the full-precision sum_in + carry_in.

Function
REQ-013 SHALL define NSEG = ceil(W/CHUNK); the last segment covers bits (NSEG-1)*CHUNK..W-1 and may be narrower than CHUNK.
REQ-014 SHALL implement three states: IDLE, BUSY, DONE.
REQ-015 SHALL drive ready_in = (state==IDLE) || (state==DONE && ready_out).
REQ-016 SHALL accept an operand pair on an edge where valid_in && ready_in, registering sum_in and carry_in, clearing the segment counter and the carry register, and entering BUSY.
REQ-017 SHALL, on each edge in BUSY, add segment k of both registered operands plus the carry register, write the segment result into result bits, store the segment carry-out, and increment k.
REQ-018 SHALL move from BUSY to DONE on the edge that processes segment NSEG-1, loading cout_out from that segment's carry-out.
REQ-019 SHALL hold valid_out high exactly while in DONE; first valid_out cycle is NSEG+1 cycles after the accepting cycle.
REQ-020 SHALL keep result_out and cout_out stable while valid_out is high and ready_out is low.
REQ-021 SHALL, on a DONE edge with ready_out high: enter BUSY with the new pair if valid_in is high (back-to-back, no bubble), else enter IDLE.
REQ-022 SHALL ignore valid_in while in BUSY, with ready_in low.
REQ-023 SHALL, when CHUNK==W, complete in one BUSY cycle (NSEG=1).
REQ-024 SHALL produce identical results regardless of how long the result is stalled downstream.

Reset
REQ-025 SHALL, on reset, enter IDLE, clear the segment counter and carry register, and drive valid_out=0, result_out=0, cout_out=0.
REQ-026 SHALL, on reset asserted in BUSY or DONE, discard the in-flight operation with no later valid_out for it.
REQ-027 SHALL drive ready_in=1 on the first cycle after reset deasserts.

Structure
REQ-028 SHALL keep the state enum local to the module; no shared-package typedefs or constants are required.
REQ-029 SHALL contain no sub-module; the segment adder is a single CHUNK+1-bit addition indexed by the segment counter.
REQ-030 SHALL size the segment counter as $clog2(NSEG), with a minimum of 1 bit.
REQ-031 SHALL statically assert CHUNK >= 1 and CHUNK <= W.

Verification
REQ-032 SHALL cover: W=16, CHUNK=4, sum=0x00FF, carry=0x0001, ready_out=1 -> result 0x0100, cout 0, valid_out first high 5 cycles after acceptance.
REQ-033 SHALL cover: sum=0xFFFF, carry=0x0001 -> result 0x0000, cout 1; carry ripples through all 4 segments.
REQ-034 SHALL cover: ready_out held low 10 cycles after result 0x1234+0x0F0F -> result 0x2143 stable throughout, ready_in low, single transfer on release.
REQ-035 SHALL cover: valid_in held high with 3 pairs and ready_out=1 -> results every 5 cycles (NSEG+1), no dropped or duplicated pairs.
REQ-036 SHALL cover: reset pulse during segment 2 of 0xAAAA+0x5555 -> no valid_out for that pair; next pair 0x0003+0x0004 -> result 0x0007.
REQ-037 SHALL cover: W=13, CHUNK=4, sum=0x1FFF, carry=0x0001 -> result 0x0000, cout 1; partial last segment of 1 bit.
